// File: rtl/line_buffer_kxk.sv
// line_buffer_kxk: rotating-bank vertical line buffer. Holds KERNEL_SIZE-1 prior
// rows and emits one KERNEL_SIZE-tall column per valid pixel, tagged with its
// centre row, with frame-edge substitution selected at run time.
module line_buffer_kxk #(
  parameter int HRES        = 640,
  parameter int VRES        = 380,
  parameter int KERNEL_SIZE = 3,
  parameter int PIXEL_WIDTH = 8
) (
  input  logic                               clk_in,
  input  logic                               rst_in,
  input  logic [10:0]                        hcount_in,
  input  logic [9:0]                         vcount_in,
  input  logic [PIXEL_WIDTH-1:0]             pixel_data_in,
  input  logic                               data_valid_in,
  input  logic [1:0]                         edge_mode_in,
  output logic [KERNEL_SIZE*PIXEL_WIDTH-1:0] line_buffer_out,
  output logic [10:0]                        hcount_out,
  output logic [9:0]                         vcount_out,
  output logic                               data_valid_out
);

  localparam int K   = KERNEL_SIZE;
  localparam int H   = (K - 1) / 2;
  localparam int AW  = (HRES > 1) ? $clog2(HRES) : 1;
  localparam int WPW = $clog2(K);

  logic           w_in_range;
  logic           w_wr;
  logic           w_row_end;
  logic           w_frame_end;
  logic [AW-1:0]  w_addr;

  logic [WPW-1:0] r_wp;
  logic           r_first_frame;

  logic [PIXEL_WIDTH-1:0] w_bank_q [K];

  // stage 0: captured alongside the pixel / BRAM address
  logic                   r_s0_vld;
  logic [10:0]            r_s0_h;
  logic [9:0]             r_s0_v;
  logic [1:0]             r_s0_mode;
  logic [PIXEL_WIDTH-1:0] r_s0_pix;
  logic [WPW-1:0]         r_s0_wp;
  logic                   r_s0_ff;

  // stage 1: aligned with the second BRAM output register
  logic                   r_s1_vld;
  logic [10:0]            r_s1_h;
  logic [9:0]             r_s1_v;
  logic [1:0]             r_s1_mode;
  logic [PIXEL_WIDTH-1:0] r_s1_pix;
  logic [WPW-1:0]         r_s1_wp;
  logic                   r_s1_ff;

  logic [K*PIXEL_WIDTH-1:0] w_col;
  logic [9:0]               w_centre;
  logic                     w_out_vld;

  assign w_in_range  = (hcount_in < 11'(HRES)) && (vcount_in < 10'(VRES));
  assign w_wr        = data_valid_in && w_in_range;
  assign w_row_end   = w_wr && (hcount_in == 11'(HRES - 1));
  assign w_frame_end = w_row_end && (vcount_in == 10'(VRES - 1));
  assign w_addr      = hcount_in[AW-1:0];

  // Write-bank rotation runs continuously across frames; first_frame masks the
  // wrap-around rows until a full previous frame exists.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_wp          <= '0;
      r_first_frame <= 1'b1;
    end else begin
      if (w_row_end)
        r_wp <= (r_wp == WPW'(K - 1)) ? '0 : r_wp + WPW'(1);
      if (w_frame_end)
        r_first_frame <= 1'b0;
    end
  end

  for (genvar b = 0; b < K; b++) begin : g_bank
    logic [PIXEL_WIDTH-1:0] r_mem [HRES];
    logic [PIXEL_WIDTH-1:0] r_rd1;
    logic [PIXEL_WIDTH-1:0] r_rd2;

    // Read-first bank with two output registers; only the current write bank is written.
    always_ff @(posedge clk_in) begin
      if (w_wr && (r_wp == WPW'(b)))
        r_mem[w_addr] <= pixel_data_in;
      r_rd1 <= r_mem[w_addr];
      r_rd2 <= r_rd1;
    end

    assign w_bank_q[b] = r_rd2;
  end

  // Control pipeline matching the BRAM latency; the bank pointer travels with its pixel.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_s0_vld  <= 1'b0;
      r_s0_h    <= '0;
      r_s0_v    <= '0;
      r_s0_mode <= '0;
      r_s0_pix  <= '0;
      r_s0_wp   <= '0;
      r_s0_ff   <= 1'b1;
      r_s1_vld  <= 1'b0;
      r_s1_h    <= '0;
      r_s1_v    <= '0;
      r_s1_mode <= '0;
      r_s1_pix  <= '0;
      r_s1_wp   <= '0;
      r_s1_ff   <= 1'b1;
    end else begin
      r_s0_vld  <= w_wr;
      r_s0_h    <= hcount_in;
      r_s0_v    <= vcount_in;
      r_s0_mode <= edge_mode_in;
      r_s0_pix  <= pixel_data_in;
      r_s0_wp   <= r_wp;
      r_s0_ff   <= r_first_frame;
      r_s1_vld  <= r_s0_vld;
      r_s1_h    <= r_s0_h;
      r_s1_v    <= r_s0_v;
      r_s1_mode <= r_s0_mode;
      r_s1_pix  <= r_s0_pix;
      r_s1_wp   <= r_s0_wp;
      r_s1_ff   <= r_s0_ff;
    end
  end

  // Map banks to taps, then substitute taps that fall outside the frame.
  always_comb begin : tap_select
    int                     idx;
    int                     lim;
    int                     src;
    logic                   top;
    logic                   inv;
    logic [PIXEL_WIDTH-1:0] tap;
    logic [PIXEL_WIDTH-1:0] raw [K];
    top = (r_s1_v >= 10'(H));
    lim = K - 1 - int'(r_s1_v);
    src = top ? lim : lim - 1;
    if (src < 0)     src = 0;
    if (src > K - 1) src = K - 1;
    idx   = 0;
    inv   = 1'b0;
    tap   = '0;
    w_col = '0;
    for (int j = 0; j < K; j++) begin
      idx = int'(r_s1_wp) + 1 + j;
      if (idx >= K) idx = idx - K;
      raw[j] = (j == K - 1) ? r_s1_pix : w_bank_q[idx];
    end
    for (int j = 0; j < K; j++) begin
      // above the top for normal rows, below the previous bottom for wrapped rows
      inv = top ? (j < lim) : (j >= lim);
      case (r_s1_mode)
        2'd0:    tap = raw[j];
        2'd1:    tap = inv ? '0 : raw[j];
        default: tap = inv ? raw[src] : raw[j];
      endcase
      w_col[j*PIXEL_WIDTH +: PIXEL_WIDTH] = tap;
    end
    w_centre  = top ? (r_s1_v - 10'(H)) : (r_s1_v - 10'(H) + 10'(VRES));
    w_out_vld = r_s1_vld && !(r_s1_ff && !top);
  end

  // Output register; the column holds its last value on idle cycles.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      line_buffer_out <= '0;
      hcount_out      <= '0;
      vcount_out      <= '0;
      data_valid_out  <= 1'b0;
    end else begin
      if (r_s1_vld)
        line_buffer_out <= w_col;
      hcount_out     <= r_s1_h;
      vcount_out     <= w_centre;
      data_valid_out <= w_out_vld;
    end
  end

endmodule

// File: tb/tb_line_buffer_kxk.sv
// Bench for line_buffer_kxk: a K=3/8-bit and a K=5/10-bit instance share one
// raster stream; a row-level reference model fills per-instance scoreboards.
module tb_line_buffer_kxk;

  localparam int HR = 8;
  localparam int VR = 6;
  localparam int KA = 3;
  localparam int PA = 8;
  localparam int KB = 5;
  localparam int PB = 10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [10:0]   hc;
  logic [9:0]    vc;
  logic          vld;
  logic [PA-1:0] pix_a;
  logic [PB-1:0] pix_b;
  logic [1:0]    mode_a;
  logic [1:0]    mode_b;

  logic [KA*PA-1:0] out_a;
  logic [10:0]      hco_a;
  logic [9:0]       vco_a;
  logic             vo_a;
  logic [KB*PB-1:0] out_b;
  logic [10:0]      hco_b;
  logic [9:0]       vco_b;
  logic             vo_b;

  line_buffer_kxk #(.HRES(HR), .VRES(VR), .KERNEL_SIZE(KA), .PIXEL_WIDTH(PA)) u_dut_a (
    .clk_in(clk), .rst_in(rst_n), .hcount_in(hc), .vcount_in(vc),
    .pixel_data_in(pix_a), .data_valid_in(vld), .edge_mode_in(mode_a),
    .line_buffer_out(out_a), .hcount_out(hco_a), .vcount_out(vco_a), .data_valid_out(vo_a)
  );

  line_buffer_kxk #(.HRES(HR), .VRES(VR), .KERNEL_SIZE(KB), .PIXEL_WIDTH(PB)) u_dut_b (
    .clk_in(clk), .rst_in(rst_n), .hcount_in(hc), .vcount_in(vc),
    .pixel_data_in(pix_b), .data_valid_in(vld), .edge_mode_in(mode_b),
    .line_buffer_out(out_b), .hcount_out(hco_b), .vcount_out(vco_b), .data_valid_out(vo_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [63:0] col;
    logic [63:0] mask;
    logic [10:0] h;
    logic [9:0]  v;
  } exp_t;

  exp_t        q_a[$];
  exp_t        q_b[$];
  exp_t        ea;
  exp_t        eb;
  logic [9:0]  mem_m [2][VR][HR];
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  bit          ff_m = 1'b1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference column built from frame rows: row r<0 lives in the previous frame.
  function automatic void model_col(input int d, input int k, input int pw, input int v,
                                    input int h, input int mode, input logic [9:0] cur,
                                    output logic [63:0] col, output logic [63:0] mask);
    int         hh;
    int         r;
    int         src;
    logic [9:0] raw [8];
    bit         inv [8];
    logic [9:0] val;
    hh   = (k - 1) / 2;
    col  = '0;
    mask = '0;
    for (int j = 0; j < k; j++) begin
      r = v - (k - 1) + j;
      if (j == k - 1)  raw[j] = cur;
      else if (r < 0)  raw[j] = mem_m[d][r + VR][h];
      else             raw[j] = mem_m[d][r][h];
      inv[j] = (v >= hh) ? (r < 0) : (r >= 0);
    end
    src = (v >= hh) ? (k - 1 - v) : (k - 2 - v);
    for (int j = 0; j < k; j++) begin
      val = raw[j];
      if (inv[j]) begin
        if (mode == 1)      val = '0;
        else if (mode >= 2) val = raw[src];
      end
      for (int b = 0; b < pw; b++) begin
        col[j*pw + b]  = val[b];
        mask[j*pw + b] = !(inv[j] && mode == 0);
      end
    end
  endfunction

  function automatic logic [9:0] centre(input int v, input int hh);
    return (v >= hh) ? 10'(v - hh) : 10'(v - hh + VR);
  endfunction

  task automatic idle();
    @(negedge clk);
    vld   = 1'b0;
    hc    = 11'($urandom_range(0, HR - 1));
    vc    = 10'($urandom_range(0, VR - 1));
    pix_a = 8'($urandom);
    pix_b = 10'($urandom);
  endtask

  task automatic drive(input int h, input int v, input logic [7:0] pa, input logic [9:0] pb,
                       input logic [1:0] ma);
    exp_t e;
    @(negedge clk);
    hc     = 11'(h);
    vc     = 10'(v);
    vld    = 1'b1;
    pix_a  = pa;
    pix_b  = pb;
    mode_a = ma;
    mode_b = 2'd2;
    if (h < HR && v < VR) begin
      if (!(ff_m && v < (KA - 1) / 2)) begin
        model_col(0, KA, PA, v, h, int'(ma), {2'b00, pa}, e.col, e.mask);
        e.cyc = cyc + 3;
        e.h   = 11'(h);
        e.v   = centre(v, (KA - 1) / 2);
        q_a.push_back(e);
      end
      if (!(ff_m && v < (KB - 1) / 2)) begin
        model_col(1, KB, PB, v, h, 2, pb, e.col, e.mask);
        e.cyc = cyc + 3;
        e.h   = 11'(h);
        e.v   = centre(v, (KB - 1) / 2);
        q_b.push_back(e);
      end
      mem_m[0][v][h] = {2'b00, pa};
      mem_m[1][v][h] = pb;
      if (h == HR - 1 && v == VR - 1) ff_m = 1'b0;
    end
  endtask

  // msel 0..3 fixed edge mode, 4 random per pixel; abort at (ab_v, ab_h) if >= 0.
  task automatic frame(input int msel, input int gap, input bit pat, input int ab_v, input int ab_h);
    logic [7:0] pa;
    logic [9:0] pb;
    logic [1:0] ma;
    for (int v = 0; v < VR; v++) begin
      for (int h = 0; h < HR; h++) begin
        if (v == ab_v && h == ab_h) return;
        while ($urandom_range(0, 99) < gap) idle();
        pa = pat ? 8'((v << 4) | h) : 8'($urandom);
        pb = ($urandom_range(0, 3) == 0) ? 10'h3FF : 10'($urandom);
        ma = (msel > 3) ? 2'($urandom_range(0, 3)) : 2'(msel);
        drive(h, v, pa, pb, ma);
        if (v == 2 && h == 3) begin
          drive(HR - 1, VR, 8'hEE, 10'h2AA, ma);
          drive(HR + 1, v, 8'hDD, 10'h155, ma);
        end
      end
    end
  endtask

  task automatic reset_check(input string tag);
    check({tag, "_vo_a"},  64'(vo_a),  64'(0));
    check({tag, "_out_a"}, 64'(out_a), 64'(0));
    check({tag, "_hv_a"},  64'({hco_a, vco_a}), 64'(0));
    check({tag, "_vo_b"},  64'(vo_b),  64'(0));
    check({tag, "_out_b"}, 64'(out_b), 64'(0));
    check({tag, "_hv_b"},  64'({hco_b, vco_b}), 64'(0));
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    vld   = 1'b0;
    q_a.delete();
    q_b.delete();
    ff_m  = 1'b1;
    repeat (2) begin
      @(negedge clk);
      reset_check(tag);
    end
    rst_n = 1'b1;
  endtask

  // Scoreboard for instance A.
  always @(posedge clk) begin
    cyc++;
    #1;
    if (vo_a) begin
      if (q_a.size() == 0) check("a_spurious", 64'(vo_a), 64'(0));
      else begin
        ea = q_a.pop_front();
        check("a_lat", 64'(cyc), 64'(ea.cyc));
        check("a_col", 64'(out_a) & ea.mask, ea.col & ea.mask);
        check("a_h",   64'(hco_a), 64'(ea.h));
        check("a_v",   64'(vco_a), 64'(ea.v));
      end
    end
  end

  // Scoreboard for instance B.
  always @(posedge clk) begin
    #1;
    if (vo_b) begin
      if (q_b.size() == 0) check("b_spurious", 64'(vo_b), 64'(0));
      else begin
        eb = q_b.pop_front();
        check("b_lat", 64'(cyc), 64'(eb.cyc));
        check("b_col", 64'(out_b) & eb.mask, eb.col & eb.mask);
        check("b_h",   64'(hco_b), 64'(eb.h));
        check("b_v",   64'(vco_b), 64'(eb.v));
      end
    end
  end

  initial begin
    rst_n  = 1'b0;
    vld    = 1'b0;
    hc     = '0;
    vc     = '0;
    pix_a  = '0;
    pix_b  = '0;
    mode_a = 2'd1;
    mode_b = 2'd2;
    for (int d = 0; d < 2; d++)
      for (int r = 0; r < VR; r++)
        for (int h = 0; h < HR; h++)
          mem_m[d][r][h] = '0;
    repeat (3) @(negedge clk);
    reset_check("por");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    frame(1, 0, 1'b1, -1, -1);
    frame(4, 0, 1'b1, -1, -1);
    frame(4, 30, 1'b0, -1, -1);
    frame(4, 30, 1'b0, -1, -1);
    frame(4, 30, 1'b0, -1, -1);

    frame(2, 0, 1'b1, 3, 4);
    do_reset("midrst");
    frame(2, 0, 1'b1, -1, -1);
    frame(0, 20, 1'b0, -1, -1);
    frame(3, 30, 1'b0, -1, -1);

    repeat (8) idle();
    check("a_drain", 64'(q_a.size()), 64'(0));
    check("b_drain", 64'(q_b.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
